// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, NOP encoding and the
// default reset vector.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage : mips_pkg

// File: rtl/if_id_reg.sv
// Pipeline register carrying valid/instr/pc/pc_plus4 between stages.
// flush overrides load; with neither asserted the contents hold.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_plus4_in,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (flush) begin
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            pc_d       = '0;
            pc_plus4_d = '0;
        end else if (load) begin
            valid_d    = 1'b1;
            instr_d    = instr_in;
            pc_d       = pc_in;
            pc_plus4_d = pc_plus4_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid_out    = valid_q;
    assign instr_out    = instr_q;
    assign pc_out       = pc_q;
    assign pc_plus4_out = pc_plus4_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC register, RUN/FAULT control, fetch counter and
// the IF/ID pipeline register feeding decode.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  count_q, count_d;
    logic [31:0]  pc_plus4;
    logic         ifid_load;
    logic         ifid_flush;

    assign pc_plus4 = pc_q + 32'd4;

    // Redirect beats stall; a misaligned target flushes and locks up in FAULT
    // without touching the PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    if (redirect_target[1:0] != 2'b00) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                    count_d   = count_q + 32'd1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (ifid_load),
        .flush        (ifid_flush),
        .instr_in     (imem_rdata),
        .pc_in        (pc_q),
        .pc_plus4_in  (pc_plus4),
        .valid_out    (if_id_valid),
        .instr_out    (if_id_instr),
        .pc_out       (if_id_pc),
        .pc_plus4_out (if_id_pc_plus4)
    );

    assign imem_addr   = pc_q;
    assign fetch_fault = (state_q == FAULT);
    assign fetch_count = count_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a small combinational ROM;
// a second instance covers the top-of-memory reset vector.
module tb_fetch_stage;

    logic        clk;
    logic        rst, rst2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        stall, stall2;
    logic        redirect_valid, redirect_valid2;
    logic [31:0] redirect_target, redirect_target2;
    logic        if_id_valid, if_id_valid2;
    logic [31:0] if_id_instr, if_id_instr2;
    logic [31:0] if_id_pc, if_id_pc2;
    logic [31:0] if_id_pc_plus4, if_id_pc_plus42;
    logic        fetch_fault, fetch_fault2;
    logic [31:0] fetch_count, fetch_count2;

    int unsigned n_cmp;
    int unsigned n_bad;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .fetch_fault     (fetch_fault),
        .fetch_count     (fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clk             (clk),
        .rst             (rst2),
        .imem_addr       (imem_addr2),
        .imem_rdata      (imem_rdata2),
        .stall           (stall2),
        .redirect_valid  (redirect_valid2),
        .redirect_target (redirect_target2),
        .if_id_valid     (if_id_valid2),
        .if_id_instr     (if_id_instr2),
        .if_id_pc        (if_id_pc2),
        .if_id_pc_plus4  (if_id_pc_plus42),
        .fetch_fault     (fetch_fault2),
        .fetch_count     (fetch_count2)
    );

    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'h0000_0004: rom = 32'h2008_0006;
            32'h0000_0008: rom = 32'h2009_000D;
            32'h0000_000C: rom = 32'h0109_5020;
            32'h0000_0010: rom = 32'h010A_4020;
            default:       rom = 32'h0000_0000;
        endcase
    endfunction

    assign imem_rdata  = rom(imem_addr);
    assign imem_rdata2 = rom(imem_addr2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [31:0] ins,
                              input logic [31:0] pc, input logic [31:0] pc4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
        check({tag, ".instr"}, if_id_instr, ins);
        check({tag, ".pc"}, if_id_pc, pc);
        check({tag, ".pc4"}, if_id_pc_plus4, pc4);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; rst2 = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        stall2 = 1'b0; redirect_valid2 = 1'b0; redirect_target2 = '0;

        repeat (2) @(posedge clk);
        #1;
        check_ifid("rst", 1'b0, 32'h0, 32'h0, 32'h0);
        check("rst.addr", imem_addr, 32'h0);
        check("rst.fault", {31'd0, fetch_fault}, 32'd0);
        check("rst.count", fetch_count, 32'd0);
        check("rst_hi.addr", imem_addr2, 32'hFFFF_FFFC);
        #3;
        rst = 1'b0; rst2 = 1'b0;

        // Free run through the ROM program
        step();
        check_ifid("run0", 1'b1, 32'h0000_0000, 32'h0, 32'h4);
        check("hi0.pc", if_id_pc2, 32'hFFFF_FFFC);
        check("hi0.pc4", if_id_pc_plus42, 32'h0);
        check("hi0.valid", {31'd0, if_id_valid2}, 32'd1);
        check("hi0.addr", imem_addr2, 32'h0);
        check("hi0.fault", {31'd0, fetch_fault2}, 32'd0);
        step();
        check_ifid("run4", 1'b1, 32'h2008_0006, 32'h4, 32'h8);
        check("hi1.pc", if_id_pc2, 32'h0);
        check("hi1.count", fetch_count2, 32'd2);
        #2;
        rst2 = 1'b1;
        #1;
        check("hi_rst.addr", imem_addr2, 32'hFFFF_FFFC);
        check("hi_rst.valid", {31'd0, if_id_valid2}, 32'd0);
        check("hi_rst.pc", if_id_pc2, 32'h0);
        check("hi_rst.count", fetch_count2, 32'd0);
        step();
        check_ifid("run8", 1'b1, 32'h2009_000D, 32'h8, 32'hC);
        step();
        check_ifid("runC", 1'b1, 32'h0109_5020, 32'hC, 32'h10);
        step();
        check_ifid("run10", 1'b1, 32'h010A_4020, 32'h10, 32'h14);
        check("run.count", fetch_count, 32'd5);
        check("run.addr", imem_addr, 32'h14);

        // Redirect back to 0x4 to set up the stall scenario
        redirect_valid = 1'b1; redirect_target = 32'h4;
        step();
        redirect_valid = 1'b0;
        check_ifid("rd4", 1'b0, 32'h0, 32'h0, 32'h0);
        check("rd4.addr", imem_addr, 32'h4);
        step();
        check_ifid("rd4.f", 1'b1, 32'h2008_0006, 32'h4, 32'h8);
        check("rd4.count", fetch_count, 32'd6);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.addr", imem_addr, 32'h8);
            check("stall.pc", if_id_pc, 32'h4);
            check("stall.count", fetch_count, 32'd6);
        end
        stall = 1'b0;
        step();
        check_ifid("resume8", 1'b1, 32'h2009_000D, 32'h8, 32'hC);
        check("resume.count", fetch_count, 32'd7);
        step();
        check("resumeC.pc", if_id_pc, 32'hC);
        check("resumeC.addr", imem_addr, 32'h10);

        // Redirect to 0x0 at PC=0x10
        redirect_valid = 1'b1; redirect_target = 32'h0;
        step();
        redirect_valid = 1'b0;
        check_ifid("rd0", 1'b0, 32'h0, 32'h0, 32'h0);
        check("rd0.addr", imem_addr, 32'h0);
        check("rd0.count", fetch_count, 32'd8);
        step();
        check_ifid("rd0.f", 1'b1, 32'h0, 32'h0, 32'h4);
        check("rd0.count2", fetch_count, 32'd9);

        // Stall and redirect together: redirect wins
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hC;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        check_ifid("srd", 1'b0, 32'h0, 32'h0, 32'h0);
        check("srd.addr", imem_addr, 32'hC);
        step();
        check_ifid("srd.f", 1'b1, 32'h0109_5020, 32'hC, 32'h10);
        check("srd.count", fetch_count, 32'd10);

        // Misaligned redirect locks into FAULT
        redirect_valid = 1'b1; redirect_target = 32'h6;
        step();
        check("flt.fault", {31'd0, fetch_fault}, 32'd1);
        check("flt.valid", {31'd0, if_id_valid}, 32'd0);
        check("flt.instr", if_id_instr, 32'h0);
        check("flt.addr", imem_addr, 32'h10);
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            redirect_valid = i[1];
            redirect_target = 32'h20 + 32'(i) * 32'd4;
            step();
            check("fltk.fault", {31'd0, fetch_fault}, 32'd1);
            check("fltk.valid", {31'd0, if_id_valid}, 32'd0);
            check("fltk.addr", imem_addr, 32'h10);
            check("fltk.count", fetch_count, 32'd10);
        end
        stall = 1'b0; redirect_valid = 1'b0;

        // Asynchronous reset mid-cycle clears the fault immediately
        #2;
        rst = 1'b1;
        #1;
        check("arst.fault", {31'd0, fetch_fault}, 32'd0);
        check("arst.addr", imem_addr, 32'h0);
        check("arst.count", fetch_count, 32'd0);
        check_ifid("arst", 1'b0, 32'h0, 32'h0, 32'h0);
        #3;
        rst = 1'b0;
        step();
        check_ifid("post", 1'b1, 32'h0, 32'h0, 32'h4);
        check("post.fault", {31'd0, fetch_fault}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the MIPS core. Holds the program counter and drives it as the address into the combinational instruction ROM. Captures the returned word plus its PC into the IF/ID pipeline register for decode. Supports pipeline stall, taken-branch/jump redirect with flush, and a sticky misaligned-redirect fault.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset; must be word-aligned.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  instruction address to ROM; equals current PC, combinational from the PC register.
- imem_rdata  in  32  instruction word from ROM; valid in the same cycle as imem_addr.
- stall  in  1  hold the PC and the IF/ID register this cycle.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_target  in  32  new PC when redirect_valid=1.
- if_id_valid  out  1  IF/ID register holds a real instruction.
- if_id_instr  out  32  captured instruction word; NOP (32'h0) when invalid.
- if_id_pc  out  32  PC of if_id_instr.
- if_id_pc_plus4  out  32  if_id_pc + 4, used by decode for branch/link targets.
- fetch_fault  out  1  sticky; set by a misaligned redirect target.
- fetch_count  out  32  instructions delivered into IF/ID since reset.

## Operation
- FSM states: RUN, FAULT. Reset enters RUN.
- RUN, per rising edge, in priority order:
  - redirect_valid=1 with redirect_target[1:0]≠0: go to FAULT, PC unchanged, IF/ID becomes bubble, fetch_fault<=1.
  - redirect_valid=1, aligned target: PC<=redirect_target, IF/ID becomes bubble (flush). Redirect overrides stall.
  - stall=1: PC, IF/ID and fetch_count hold.
  - Otherwise: if_id_instr<=imem_rdata, if_id_pc<=PC, if_id_pc_plus4<=PC+4, if_id_valid<=1, PC<=PC+4, fetch_count<=fetch_count+1.
- FAULT: PC frozen, if_id_valid=0, if_id_instr=NOP, fetch_fault=1. All inputs ignored. Exit only via rst.
- Bubble means if_id_valid=0, if_id_instr=32'h0, if_id_pc and if_id_pc_plus4 = 0.
- Arithmetic: PC+4 and fetch_count both wrap modulo 2^32. 32'hFFFFFFFC advances to 32'h00000000 with no fault.
- imem_rdata is never inspected; any word, including an undecoded address returning 0, is passed through.

## Timing
- Reset values: PC=RESET_PC, so imem_addr=RESET_PC. if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0, fetch_fault=0, fetch_count=0, state=RUN.
- Reset is asserted asynchronously and takes effect immediately, including mid-stall, mid-redirect or in FAULT. Release is sampled on the next clk edge.
- Fetch latency: 1 cycle. The word at address A appears on if_id_* on the edge after PC=A with stall=0.
- Redirect penalty: 1 bubble. Target instruction appears in IF/ID on the second edge after the redirect is sampled.
- Throughput: 1 instruction per cycle when not stalled.
- stall and redirect sampled together: redirect is taken; the stalled IF/ID content is discarded.

## Structure
- Shared package mips_pkg:
  - NOP_INSTR = 32'h00000000
  - fetch state enum (RUN, FAULT)
  - default reset vector constant
- Sub-module if_id_reg: pipeline register holding valid/instr/pc/pc_plus4, with load, flush and async reset. Reused later for ID/EX-style registers.
- PC register, FSM and fetch_count live in fetch_stage.

## Test plan
- Reset, then free-run against the ROM program: IF/ID shows pc 0 / 0x00000000, then pc 4 / 0x20080006, pc 8 / 0x2009000D, pc C / 0x01095020, pc 10 / 0x010A4020 on consecutive edges. fetch_count=5.
- stall=1 for 3 cycles while PC=0x8: imem_addr stays 0x8, if_id_pc stays 0x4, fetch_count unchanged. Fetch resumes at 0x8 on release.
- redirect_valid=1, target 0x0 at PC=0x10: next edge gives a bubble (valid=0, instr=0) and PC=0x0. The following edge gives pc 0 / 0x00000000.
- stall=1 and redirect to 0xC in the same cycle: redirect wins, bubble. Next valid instruction is 0x01095020 at pc 0xC.
- Redirect to 0x6: fetch_fault=1, valid stays 0, PC frozen through 10 cycles of stimulus. rst clears fault and restores PC=RESET_PC.
- RESET_PC=32'hFFFFFFFC: first fetch at 0xFFFFFFFC, if_id_pc_plus4=0x0, next PC 0x0, no fault. rst asserted mid-run returns all outputs to reset values within the same cycle.
